// File: rtl/serial_paralelo_rx_pkg.sv
// Shared constants and state encoding for the serial-to-parallel receive lane.
//   COM_SYM : alignment / idle symbol
//   SKP_SYM : skip symbol, reserved for a later revision
//   state_e : lock FSM states of the byte aligner
package serial_paralelo_rx_pkg;

   localparam logic [7:0] COM_SYM = 8'hBC;
   localparam logic [7:0] SKP_SYM = 8'h7C;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

endpackage

// File: rtl/serial_paralelo_rx_aligner.sv
// Byte aligner: shift register, bit counter and COM lock FSM.
//   clk_32f_i        bit clock
//   rst_n_i          async active-low reset
//   data_in_serial_i serial input, MSB first
//   cand_o           candidate byte {sr[6:0], data_in_serial}
//   boundary_o       high on the edge that samples the 8th bit of an aligned byte (LOCKED only)
//   active_o         lane locked
module serial_paralelo_rx_aligner
   import serial_paralelo_rx_pkg::*;
#(
   parameter logic [7:0] COM        = COM_SYM,
   parameter int         LOCK_COUNT = 4
) (
   input  logic       clk_32f_i,
   input  logic       rst_n_i,
   input  logic       data_in_serial_i,
   output logic [7:0] cand_o,
   output logic       boundary_o,
   output logic       active_o
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

   state_e     state_q, state_d;
   logic [7:0] sr_q;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] com_cnt_q, com_cnt_d;
   logic       is_com;

   assign cand_o = {sr_q[6:0], data_in_serial_i};
   assign is_com = (cand_o == COM);

   // state register (plus datapath registers that advance with it)
   always_ff @(posedge clk_32f_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_SEARCH;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         com_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sr_q      <= cand_o;
         bit_cnt_q <= bit_cnt_d;
         com_cnt_q <= com_cnt_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d   = state_q;
      com_cnt_d = com_cnt_q;
      bit_cnt_d = bit_cnt_q + 3'd1;
      case (state_q)
         ST_SEARCH: begin
            // sliding compare; a hit restarts the bit counter so the next 8 bits form a byte
            if (is_com) begin
               state_d   = ST_ALIGN;
               com_cnt_d = 4'd1;
               bit_cnt_d = 3'd0;
            end
         end
         ST_ALIGN: begin
            if (bit_cnt_q == 3'd7) begin
               if (is_com) begin
                  if (com_cnt_q + 4'd1 == LOCK_N) state_d = ST_LOCKED;
                  else                            com_cnt_d = com_cnt_q + 4'd1;
               end else begin
                  state_d   = ST_SEARCH;
                  com_cnt_d = 4'd0;
               end
            end
         end
         default: ;  // LOCKED is left only through reset
      endcase
   end

   // output logic
   always_comb begin
      active_o   = (state_q == ST_LOCKED);
      boundary_o = (state_q == ST_LOCKED) && (bit_cnt_q == 3'd7);
   end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Receive-lane front end: aligns the serial stream on COM, then rebuilds
// data bytes and packs them into 32-bit words (first byte in [31:24]).
//   clk_32f         bit clock
//   reset           async active-low reset
//   data_in_serial  serial input, MSB first
//   active          lane locked
//   data_out_byte   last recovered data byte, valid_byte pulses when new
//   data_out_word   last assembled word, valid_word pulses when new
//   word_drop       pulse when an idle COM discards a partial word
module serial_paralelo_rx
   import serial_paralelo_rx_pkg::*;
#(
   parameter logic [7:0] COM        = COM_SYM,
   parameter int         LOCK_COUNT = 4
) (
   input  logic        clk_32f,
   input  logic        reset,
   input  logic        data_in_serial,
   output logic        active,
   output logic [7:0]  data_out_byte,
   output logic        valid_byte,
   output logic [31:0] data_out_word,
   output logic        valid_word,
   output logic        word_drop
);

   logic [7:0]  cand;
   logic        boundary;

   logic [1:0]  idx_q, idx_d;
   logic [31:0] buf_q, buf_d;
   logic [7:0]  byte_q, byte_d;
   logic [31:0] word_q, word_d;
   logic        vb_q, vb_d, vw_q, vw_d, drop_q, drop_d;

   serial_paralelo_rx_aligner #(
      .COM        (COM),
      .LOCK_COUNT (LOCK_COUNT)
   ) u_aligner (
      .clk_32f_i        (clk_32f),
      .rst_n_i          (reset),
      .data_in_serial_i (data_in_serial),
      .cand_o           (cand),
      .boundary_o       (boundary),
      .active_o         (active)
   );

   always_comb begin
      idx_d  = idx_q;
      buf_d  = buf_q;
      byte_d = byte_q;
      word_d = word_q;
      vb_d   = 1'b0;
      vw_d   = 1'b0;
      drop_d = 1'b0;
      if (boundary) begin
         if (cand == COM) begin
            // idle symbol; anything collected so far is an incomplete word
            if (idx_q != 2'd0) begin
               drop_d = 1'b1;
               idx_d  = 2'd0;
            end
         end else begin
            byte_d = cand;
            vb_d   = 1'b1;
            idx_d  = idx_q + 2'd1;
            case (idx_q)
               2'd0:    buf_d[31:24] = cand;
               2'd1:    buf_d[23:16] = cand;
               2'd2:    buf_d[15:8]  = cand;
               default: begin
                  word_d = {buf_q[31:8], cand};
                  vw_d   = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         idx_q  <= '0;
         buf_q  <= '0;
         byte_q <= '0;
         word_q <= '0;
         vb_q   <= 1'b0;
         vw_q   <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         buf_q  <= buf_d;
         byte_q <= byte_d;
         word_q <= word_d;
         vb_q   <= vb_d;
         vw_q   <= vw_d;
         drop_q <= drop_d;
      end
   end

   assign data_out_byte = byte_q;
   assign valid_byte    = vb_q;
   assign data_out_word = word_q;
   assign valid_word    = vw_q;
   assign word_drop     = drop_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx with a cycle-stamped scoreboard for
// byte, word and drop pulses.
module tb_serial_paralelo_rx;

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } exp_t;

   logic        clk_32f = 1'b0;
   logic        reset = 1'b0;
   logic        data_in_serial = 1'b0;
   logic        active, valid_byte, valid_word, word_drop;
   logic [7:0]  data_out_byte;
   logic [31:0] data_out_word;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t q_byte[$];
   exp_t q_word[$];
   exp_t q_drop[$];

   serial_paralelo_rx dut (
      .clk_32f        (clk_32f),
      .reset          (reset),
      .data_in_serial (data_in_serial),
      .active         (active),
      .data_out_byte  (data_out_byte),
      .valid_byte     (valid_byte),
      .data_out_word  (data_out_word),
      .valid_word     (valid_word),
      .word_drop      (word_drop)
   );

   always #5 clk_32f = ~clk_32f;
   always @(posedge clk_32f) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // scoreboard: every pulse must match the head entry's cycle and value,
   // and an entry whose cycle has passed without a pulse is a miss
   always begin
      exp_t e;
      @(posedge clk_32f);
      #1;
      if (q_byte.size() != 0 && q_byte[0].cyc < cyc) begin
         e = q_byte.pop_front();
         chk("byte_miss", cyc, e.cyc);
      end
      if (q_word.size() != 0 && q_word[0].cyc < cyc) begin
         e = q_word.pop_front();
         chk("word_miss", cyc, e.cyc);
      end
      if (q_drop.size() != 0 && q_drop[0].cyc < cyc) begin
         e = q_drop.pop_front();
         chk("drop_miss", cyc, e.cyc);
      end
      if (valid_byte) begin
         if (q_byte.size() == 0) chk("byte_unexp", {31'd0, valid_byte}, 32'd0);
         else begin
            e = q_byte.pop_front();
            chk("byte_cyc", cyc, e.cyc);
            chk("byte_val", {24'd0, data_out_byte}, e.val);
         end
      end
      if (valid_word) begin
         if (q_word.size() == 0) chk("word_unexp", {31'd0, valid_word}, 32'd0);
         else begin
            e = q_word.pop_front();
            chk("word_cyc", cyc, e.cyc);
            chk("word_val", data_out_word, e.val);
         end
      end
      if (word_drop) begin
         if (q_drop.size() == 0) chk("drop_unexp", {31'd0, word_drop}, 32'd0);
         else begin
            e = q_drop.pop_front();
            chk("drop_cyc", cyc, e.cyc);
         end
      end
   end

   task automatic send_bit(input logic b);
      @(negedge clk_32f);
      data_in_serial = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   // expectations are pushed from the posedge+1 point, so the pulse lands 8 edges later
   task automatic push_byte(input logic [7:0] v);
      q_byte.push_back('{cyc + 8, {24'd0, v}});
   endtask

   task automatic push_word(input logic [31:0] v);
      q_word.push_back('{cyc + 8, v});
   endtask

   task automatic push_drop();
      q_drop.push_back('{cyc + 8, 32'd0});
   endtask

   task automatic data(input logic [7:0] b);
      push_byte(b);
      send_byte(b);
   endtask

   initial begin
      logic [7:0] com;
      com = 8'hBC;

      // reset with random serial input
      reset = 1'b0;
      repeat (5) begin
         @(negedge clk_32f);
         data_in_serial = 1'($urandom_range(0, 1));
      end
      @(posedge clk_32f);
      #1;
      chk("rst_active",    {31'd0, active},        32'd0);
      chk("rst_byte",      {24'd0, data_out_byte}, 32'd0);
      chk("rst_vbyte",     {31'd0, valid_byte},    32'd0);
      chk("rst_word",      data_out_word,          32'd0);
      chk("rst_vword",     {31'd0, valid_word},    32'd0);
      chk("rst_drop",      {31'd0, word_drop},     32'd0);
      @(negedge clk_32f);
      reset = 1'b1;

      // garbage, then an aborted lock attempt
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("garbage_active", {31'd0, active}, 32'd0);
      repeat (3) send_byte(com);
      send_byte(8'h55);
      chk("abort_active", {31'd0, active}, 32'd0);

      // full lock: active must rise exactly on the last bit of the 4th COM
      repeat (3) send_byte(com);
      for (int i = 7; i >= 1; i--) send_bit(com[i]);
      chk("lock_pre", {31'd0, active}, 32'd0);
      send_bit(com[0]);
      chk("lock_post", {31'd0, active}, 32'd1);

      // one complete word
      data(8'hDE);
      data(8'hAD);
      data(8'hBE);
      push_word(32'hDEADBEEF);
      data(8'hEF);
      send_byte(com);
      chk("word_hold", data_out_word, 32'hDEADBEEF);

      // idle symbols in the middle of a word
      data(8'h12);
      data(8'h34);
      push_drop();
      send_byte(com);
      data(8'h56);
      data(8'h78);
      data(8'h9A);
      push_drop();
      send_byte(com);
      chk("idle_word_hold", data_out_word, 32'hDEADBEEF);
      chk("idle_byte_hold", {24'd0, data_out_byte}, 32'h9A);

      // reset in the middle of a word
      data(8'h11);
      data(8'h22);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      @(negedge clk_32f);
      reset = 1'b0;
      #1;
      chk("midrst_active", {31'd0, active},        32'd0);
      chk("midrst_byte",   {24'd0, data_out_byte}, 32'd0);
      chk("midrst_word",   data_out_word,          32'd0);
      chk("midrst_vbyte",  {31'd0, valid_byte},    32'd0);
      repeat (3) @(negedge clk_32f);
      reset = 1'b1;

      // relock and a fresh word starting at slot 0
      repeat (4) send_byte(com);
      chk("relock_active", {31'd0, active}, 32'd1);
      data(8'h01);
      data(8'h02);
      data(8'h03);
      push_word(32'h01020304);
      data(8'h04);
      send_byte(com);
      chk("relock_word", data_out_word, 32'h01020304);
      chk("q_byte_left", q_byte.size(), 32'd0);
      chk("q_word_left", q_word.size(), 32'd0);
      chk("q_drop_left", q_drop.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
